// File: rtl/ofm_reader.sv
// ofm_reader: drains 4-lane OFM words from a base address and streams them out
// one byte at a time over a valid/ready handshake, lane 0 first.
module ofm_reader #(
   parameter int ADDR_W = 8,
   parameter int CNT_W  = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic [CNT_W-1:0]  word_count,
   output logic              mem_rd,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic [31:0]       mem_rdata,
   output logic [7:0]        out_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              out_last,
   output logic              busy,
   output logic              done
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_REQ,
      S_WAIT,
      S_SEND,
      S_FIN
   } state_t;

   localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0]  CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0]  CNT_ZERO = '0;

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [1:0]        lane_q, lane_d;
   logic [31:0]       word_q, word_d;
   logic              mem_rd_q, mem_rd_d;
   logic [7:0]        out_data_q, out_data_d;
   logic              out_valid_q, out_valid_d;
   logic              out_last_q, out_last_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic              zero_start;

   // Next-state logic; outputs are precomputed from the next state so they leave
   // the block straight from flops and out_ready never reaches them combinationally.
   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      cnt_d   = cnt_q;
      lane_d  = lane_q;
      word_d  = word_q;

      case (state_q)
         S_IDLE: begin
            if (start) begin
               addr_d = base_addr;
               cnt_d  = word_count;
               if (word_count == CNT_ZERO) begin
                  state_d = S_FIN;
               end else begin
                  state_d = S_REQ;
               end
            end
         end
         S_REQ: begin
            state_d = S_WAIT;
         end
         S_WAIT: begin
            word_d  = mem_rdata;
            lane_d  = 2'd0;
            state_d = S_SEND;
         end
         S_SEND: begin
            if (out_ready) begin
               if (lane_q != 2'd3) begin
                  lane_d = lane_q + 2'd1;
               end else begin
                  cnt_d  = cnt_q - CNT_ONE;
                  addr_d = addr_q + ADDR_ONE;
                  if (cnt_q == CNT_ONE) begin
                     state_d = S_FIN;
                  end else begin
                     state_d = S_REQ;
                  end
               end
            end
         end
         S_FIN: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      mem_rd_d    = (state_d == S_REQ);
      out_valid_d = (state_d == S_SEND);
      out_data_d  = (state_d == S_SEND) ? word_d[8*lane_d +: 8] : 8'h00;
      out_last_d  = (state_d == S_SEND) && (lane_d == 2'd3) && (cnt_d == CNT_ONE);
      busy_d      = (state_d == S_REQ) || (state_d == S_WAIT) || (state_d == S_SEND);
      done_d      = (state_d == S_FIN);
   end

   // State, datapath and output registers; reset aborts any drain in flight.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= S_IDLE;
         addr_q      <= '0;
         cnt_q       <= '0;
         lane_q      <= 2'd0;
         word_q      <= 32'h0;
         mem_rd_q    <= 1'b0;
         out_data_q  <= 8'h00;
         out_valid_q <= 1'b0;
         out_last_q  <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         addr_q      <= addr_d;
         cnt_q       <= cnt_d;
         lane_q      <= lane_d;
         word_q      <= word_d;
         mem_rd_q    <= mem_rd_d;
         out_data_q  <= out_data_d;
         out_valid_q <= out_valid_d;
         out_last_q  <= out_last_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
      end
   end

   // A zero-count drain never leaves IDLE through a busy state, so busy covers
   // its accept cycle directly from the start request.
   assign zero_start = rst && (state_q == S_IDLE) && start && (word_count == CNT_ZERO);

   assign mem_rd    = mem_rd_q;
   assign mem_addr  = addr_q;
   assign out_data  = out_data_q;
   assign out_valid = out_valid_q;
   assign out_last  = out_last_q;
   assign busy      = busy_q | zero_start;
   assign done      = done_q;

endmodule

// File: tb/tb_ofm_reader.sv
// tb_ofm_reader: directed checks of the OFM drain engine against a simple
// registered memory model and hand-computed byte streams.
module tb_ofm_reader;

   logic        clk;
   logic        rst;
   logic        start;
   logic [7:0]  base_addr;
   logic [7:0]  word_count;
   logic        mem_rd;
   logic [7:0]  mem_addr;
   logic [31:0] mem_rdata;
   logic [7:0]  out_data;
   logic        out_valid;
   logic        out_ready;
   logic        out_last;
   logic        busy;
   logic        done;

   logic [31:0] mem [256];

   int checks;
   int errors;

   logic [7:0] rd_q[$];
   logic [7:0] byte_q[$];
   logic       last_q[$];
   int         done_cnt;
   int         hold_errs;
   bit         timed_out;

   ofm_reader #(.ADDR_W(8), .CNT_W(8)) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .base_addr  (base_addr),
      .word_count (word_count),
      .mem_rd     (mem_rd),
      .mem_addr   (mem_addr),
      .mem_rdata  (mem_rdata),
      .out_data   (out_data),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_last   (out_last),
      .busy       (busy),
      .done       (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // OFM read port model: data appears the cycle after the read strobe.
   always @(posedge clk) begin
      if (mem_rd === 1'b1) mem_rdata <= mem[mem_addr];
   end

   // Runs one drain and records reads, handshaken bytes, done pulses and hold violations.
   task automatic run_drain(input logic [7:0] base, input logic [7:0] cnt,
                            input bit toggle, input bit restart);
      bit         pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
      bit         pulse;
      bit         restarted;
      bit         hold_pend;
      logic [7:0] hold_data;
      logic       hold_last;
      int         tail;
      rd_q.delete();
      byte_q.delete();
      last_q.delete();
      done_cnt   = 0;
      hold_errs  = 0;
      timed_out  = 1'b1;
      pulse      = 1'b0;
      restarted  = 1'b0;
      hold_pend  = 1'b0;
      hold_data  = 8'h00;
      hold_last  = 1'b0;
      tail       = 0;
      base_addr  = base;
      word_count = cnt;
      start      = 1'b1;
      for (int k = 0; k < 400; k++) begin
         if (k > 0) begin
            start = pulse;
            if (pulse) begin
               base_addr  = 8'h80;
               word_count = 8'd5;
            end
            pulse = 1'b0;
         end
         out_ready = toggle ? pat[k % 4] : 1'b1;
         @(negedge clk);
         if (hold_pend && (out_valid !== 1'b1 || out_data !== hold_data || out_last !== hold_last))
            hold_errs++;
         hold_pend = (out_valid === 1'b1) && (out_ready === 1'b0);
         hold_data = out_data;
         hold_last = out_last;
         if (mem_rd === 1'b1) rd_q.push_back(mem_addr);
         if (out_valid === 1'b1 && out_ready === 1'b1) begin
            byte_q.push_back(out_data);
            last_q.push_back(out_last);
         end
         if (done === 1'b1) done_cnt++;
         if (restart && !restarted && out_valid === 1'b1) begin
            pulse     = 1'b1;
            restarted = 1'b1;
         end
         if (done_cnt > 0) tail++;
         @(posedge clk);
         #1;
         if (tail >= 10) begin
            timed_out = 1'b0;
            break;
         end
      end
      start     = 1'b0;
      out_ready = 1'b1;
   endtask

   // Asserts reset and checks every output is cleared.
   task automatic test_reset();
      rst = 1'b0;
      #2;
      checks++; if (mem_rd !== 1'b0) begin errors++; $display("[TB] FAIL reset_mem_rd: got %b expected 0", mem_rd); end
      checks++; if (mem_addr !== 8'h00) begin errors++; $display("[TB] FAIL reset_mem_addr: got %h expected 00", mem_addr); end
      checks++; if (out_data !== 8'h00) begin errors++; $display("[TB] FAIL reset_out_data: got %h expected 00", out_data); end
      checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_out_valid: got %b expected 0", out_valid); end
      checks++; if (out_last !== 1'b0) begin errors++; $display("[TB] FAIL reset_out_last: got %b expected 0", out_last); end
      checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
      checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL reset_done: got %b expected 0", done); end
      @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
   endtask

   // Single word from 0x10 with ready held high; checks exact cycle timing.
   task automatic test_single();
      logic [7:0] exp [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
      base_addr  = 8'h10;
      word_count = 8'd1;
      out_ready  = 1'b1;
      start      = 1'b1;
      @(negedge clk);
      checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL single_c0_busy: got %b expected 0", busy); end
      checks++; if (mem_rd !== 1'b0) begin errors++; $display("[TB] FAIL single_c0_mem_rd: got %b expected 0", mem_rd); end
      @(posedge clk); #1; start = 1'b0;
      @(negedge clk);
      checks++; if (mem_rd !== 1'b1) begin errors++; $display("[TB] FAIL single_c1_mem_rd: got %b expected 1", mem_rd); end
      checks++; if (mem_addr !== 8'h10) begin errors++; $display("[TB] FAIL single_c1_mem_addr: got %h expected 10", mem_addr); end
      checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL single_c1_busy: got %b expected 1", busy); end
      @(posedge clk); #1;
      @(negedge clk);
      checks++; if (mem_rd !== 1'b0) begin errors++; $display("[TB] FAIL single_c2_mem_rd: got %b expected 0", mem_rd); end
      checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL single_c2_out_valid: got %b expected 0", out_valid); end
      for (int i = 0; i < 4; i++) begin
         @(posedge clk); #1;
         @(negedge clk);
         checks++; if (out_valid !== 1'b1) begin errors++; $display("[TB] FAIL single_valid_%0d: got %b expected 1", i, out_valid); end
         checks++; if (out_data !== exp[i]) begin errors++; $display("[TB] FAIL single_data_%0d: got %h expected %h", i, out_data, exp[i]); end
         checks++; if (out_last !== (i == 3)) begin errors++; $display("[TB] FAIL single_last_%0d: got %b expected %b", i, out_last, (i == 3)); end
         checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL single_early_done_%0d: got %b expected 0", i, done); end
      end
      @(posedge clk); #1;
      @(negedge clk);
      checks++; if (done !== 1'b1) begin errors++; $display("[TB] FAIL single_c7_done: got %b expected 1", done); end
      checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL single_c7_busy: got %b expected 0", busy); end
      checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL single_c7_out_valid: got %b expected 0", out_valid); end
      @(posedge clk); #1;
      @(negedge clk);
      checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL single_c8_done: got %b expected 0", done); end
      @(posedge clk); #1;
   endtask

   // Three words from 0x20 with out_ready toggling 1,0,0,1.
   task automatic test_backpressure();
      logic [7:0] exp [12] = '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hB0, 8'hB1, 8'hB2, 8'hB3,
                               8'hC0, 8'hC1, 8'hC2, 8'hC3};
      run_drain(8'h20, 8'd3, 1'b1, 1'b0);
      checks++; if (timed_out) begin errors++; $display("[TB] FAIL bp_timeout: got no done expected done"); end
      checks++; if (byte_q.size() != 12) begin errors++; $display("[TB] FAIL bp_byte_count: got %0d expected 12", byte_q.size()); end
      for (int i = 0; i < 12 && i < byte_q.size(); i++) begin
         checks++; if (byte_q[i] !== exp[i]) begin errors++; $display("[TB] FAIL bp_byte_%0d: got %h expected %h", i, byte_q[i], exp[i]); end
      end
      checks++; if (hold_errs != 0) begin errors++; $display("[TB] FAIL bp_hold: got %0d unstable cycles expected 0", hold_errs); end
      checks++; if (rd_q.size() != 3) begin errors++; $display("[TB] FAIL bp_read_count: got %0d expected 3", rd_q.size()); end
      for (int i = 0; i < 3 && i < rd_q.size(); i++) begin
         checks++; if (rd_q[i] !== 8'(8'h20 + i)) begin errors++; $display("[TB] FAIL bp_read_addr_%0d: got %h expected %h", i, rd_q[i], 8'(8'h20 + i)); end
      end
      checks++; if (last_q.size() == 12 && last_q[11] !== 1'b1) begin errors++; $display("[TB] FAIL bp_last: got %b expected 1", last_q[11]); end
      checks++; if (done_cnt != 1) begin errors++; $display("[TB] FAIL bp_done_count: got %0d expected 1", done_cnt); end
   endtask

   // Zero-count drain: immediate done, busy only in the accept cycle.
   task automatic test_zero_count();
      base_addr  = 8'h33;
      word_count = 8'd0;
      out_ready  = 1'b1;
      start      = 1'b1;
      @(negedge clk);
      checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL zero_c0_busy: got %b expected 1", busy); end
      checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL zero_c0_done: got %b expected 0", done); end
      @(posedge clk); #1; start = 1'b0;
      @(negedge clk);
      checks++; if (done !== 1'b1) begin errors++; $display("[TB] FAIL zero_c1_done: got %b expected 1", done); end
      checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL zero_c1_busy: got %b expected 0", busy); end
      for (int i = 2; i < 6; i++) begin
         @(posedge clk); #1;
         @(negedge clk);
         checks++; if ({mem_rd, out_valid, busy, done} !== 4'b0000) begin errors++; $display("[TB] FAIL zero_idle_c%0d: got rd/valid/busy/done %b expected 0000", i, {mem_rd, out_valid, busy, done}); end
      end
      @(posedge clk); #1;
   endtask

   // Base 0xFF, two words: address wraps to 0x00.
   task automatic test_wrap();
      logic [7:0] exp [8] = '{8'h0A, 8'h0B, 8'h0C, 8'h0D, 8'h1A, 8'h1B, 8'h1C, 8'h1D};
      run_drain(8'hFF, 8'd2, 1'b0, 1'b0);
      checks++; if (timed_out) begin errors++; $display("[TB] FAIL wrap_timeout: got no done expected done"); end
      checks++; if (rd_q.size() != 2) begin errors++; $display("[TB] FAIL wrap_read_count: got %0d expected 2", rd_q.size()); end
      if (rd_q.size() == 2) begin
         checks++; if (rd_q[0] !== 8'hFF) begin errors++; $display("[TB] FAIL wrap_addr0: got %h expected ff", rd_q[0]); end
         checks++; if (rd_q[1] !== 8'h00) begin errors++; $display("[TB] FAIL wrap_addr1: got %h expected 00", rd_q[1]); end
      end
      checks++; if (byte_q.size() != 8) begin errors++; $display("[TB] FAIL wrap_byte_count: got %0d expected 8", byte_q.size()); end
      for (int i = 0; i < 8 && i < byte_q.size(); i++) begin
         checks++; if (byte_q[i] !== exp[i]) begin errors++; $display("[TB] FAIL wrap_byte_%0d: got %h expected %h", i, byte_q[i], exp[i]); end
         checks++; if (last_q[i] !== (i == 7)) begin errors++; $display("[TB] FAIL wrap_last_%0d: got %b expected %b", i, last_q[i], (i == 7)); end
      end
   endtask

   // A second start while sending must be ignored.
   task automatic test_restart_ignored();
      logic [7:0] exp [8] = '{8'h50, 8'h51, 8'h52, 8'h53, 8'h54, 8'h55, 8'h56, 8'h57};
      run_drain(8'h50, 8'd2, 1'b0, 1'b1);
      checks++; if (timed_out) begin errors++; $display("[TB] FAIL restart_timeout: got no done expected done"); end
      checks++; if (done_cnt != 1) begin errors++; $display("[TB] FAIL restart_done_count: got %0d expected 1", done_cnt); end
      checks++; if (rd_q.size() != 2) begin errors++; $display("[TB] FAIL restart_read_count: got %0d expected 2", rd_q.size()); end
      checks++; if (byte_q.size() != 8) begin errors++; $display("[TB] FAIL restart_byte_count: got %0d expected 8", byte_q.size()); end
      for (int i = 0; i < 8 && i < byte_q.size(); i++) begin
         checks++; if (byte_q[i] !== exp[i]) begin errors++; $display("[TB] FAIL restart_byte_%0d: got %h expected %h", i, byte_q[i], exp[i]); end
      end
   endtask

   // Reset during the second byte aborts cleanly; a fresh drain then works.
   task automatic test_reset_mid_drain();
      logic [7:0] exp [4] = '{8'h61, 8'h62, 8'h63, 8'h64};
      base_addr  = 8'h30;
      word_count = 8'd2;
      out_ready  = 1'b1;
      start      = 1'b1;
      @(posedge clk); #1; start = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
      end
      checks++; if (out_valid !== 1'b1 || out_data !== 8'h32) begin errors++; $display("[TB] FAIL rstmid_second_byte: got valid %b data %h expected valid 1 data 32", out_valid, out_data); end
      #2;
      rst = 1'b0;
      #1;
      checks++; if ({mem_rd, out_valid, out_last, busy, done} !== 5'b00000) begin errors++; $display("[TB] FAIL rstmid_ctrl_zero: got rd/valid/last/busy/done %b expected 00000", {mem_rd, out_valid, out_last, busy, done}); end
      checks++; if (out_data !== 8'h00 || mem_addr !== 8'h00) begin errors++; $display("[TB] FAIL rstmid_data_zero: got data %h addr %h expected 00 00", out_data, mem_addr); end
      for (int i = 0; i < 6; i++) begin
         if (i == 2) begin
            @(posedge clk); #1; rst = 1'b1;
         end else begin
            @(posedge clk); #1;
         end
         @(negedge clk);
         checks++; if (done !== 1'b0 || out_valid !== 1'b0) begin errors++; $display("[TB] FAIL rstmid_quiet_%0d: got done %b valid %b expected 0 0", i, done, out_valid); end
      end
      @(posedge clk); #1;
      run_drain(8'h40, 8'd1, 1'b0, 1'b0);
      checks++; if (timed_out || done_cnt != 1) begin errors++; $display("[TB] FAIL rstmid_new_done: got %0d dones expected 1", done_cnt); end
      checks++; if (byte_q.size() != 4) begin errors++; $display("[TB] FAIL rstmid_new_count: got %0d expected 4", byte_q.size()); end
      for (int i = 0; i < 4 && i < byte_q.size(); i++) begin
         checks++; if (byte_q[i] !== exp[i] || last_q[i] !== (i == 3)) begin errors++; $display("[TB] FAIL rstmid_new_byte_%0d: got %h last %b expected %h last %b", i, byte_q[i], last_q[i], exp[i], (i == 3)); end
      end
   endtask

   // Test sequence.
   initial begin
      checks     = 0;
      errors     = 0;
      rst        = 1'b0;
      start      = 1'b0;
      base_addr  = 8'h00;
      word_count = 8'h00;
      out_ready  = 1'b1;
      mem_rdata  = 32'h0;
      for (int i = 0; i < 256; i++) mem[i] = 32'hEEEEEEEE;
      mem[8'h10] = 32'h44332211;
      mem[8'h20] = 32'hA3A2A1A0;
      mem[8'h21] = 32'hB3B2B1B0;
      mem[8'h22] = 32'hC3C2C1C0;
      mem[8'hFF] = 32'h0D0C0B0A;
      mem[8'h00] = 32'h1D1C1B1A;
      mem[8'h50] = 32'h53525150;
      mem[8'h51] = 32'h57565554;
      mem[8'h30] = 32'h34333231;
      mem[8'h31] = 32'h38373635;
      mem[8'h40] = 32'h64636261;
      @(posedge clk); #1;
      test_reset();
      test_single();
      test_backpressure();
      test_zero_count();
      test_wrap();
      test_restart_ignored();
      test_reset_mid_drain();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
